// File: rtl/mem_responder.sv
// mem_responder: fixed-latency backing store below the L2, with deterministic default contents.
// Define MEM_RESPONDER_STATS_EN to add saturating read/write accept counters (rd_count, wr_count).
module mem_responder #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);
  // state | meaning
  // IDLE  | ready to accept one request
  // WAIT  | latency countdown for the accepted request
  // RESP  | response presented, held until resp_ready

  localparam int         DEPTH    = 2**ADDR_WIDTH;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_value;

  assign accept   = req_valid & req_ready;
  // Unwritten words read back as their own address, so benches need no preload.
  assign rd_value = written[addr_q] ? mem[addr_q] : DATA_WIDTH'(addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            cnt       <= CNT_LOAD;
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= write_q ? wdata_q : rd_value;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Writes commit at the accept edge so any later read sees them.
  always_ff @(posedge clk) begin
    if (accept && req_write) mem[req_addr] <= req_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) written <= '0;
    else if (accept && req_write) written[req_addr] <= 1'b1;
  end

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (accept) begin
      if (!req_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (req_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected responses, LATENCY=4 and LATENCY=1 instances.
module tb_mem_responder;
  localparam int AW = 11;
  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic          req_valid, req_ready, req_write, resp_valid, resp_ready, busy;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, resp_data;
  logic          b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_busy;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_resp_data;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0]   rd_count, wr_count, b_rd_count, b_wr_count;
`endif

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .busy(b_busy)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(b_rd_count), .wr_count(b_wr_count)
`endif
  );

  logic [DW-1:0] mem_m [2**AW];
  bit            written_m [2**AW];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return written_m[a] ? mem_m[a] : DW'(a);
  endfunction

  task automatic clear_model;
    foreach (written_m[i]) written_m[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk); #1; acc = cycle; break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout addr=%h: req_ready never 1", a);
    end else if (wr) begin
      mem_m[a] = d; written_m[a] = 1'b1; exp_q.push_back(d);
    end else begin
      exp_q.push_back(model_read(a));
    end
  endtask

  task automatic collect(input int acc, input int lat, input string name, output logic [DW-1:0] exp);
    int k;
    exp = '0;
    for (k = 0; k < 300 && resp_valid !== 1'b1; k++) begin
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_wait: got %b want 1", name, busy); end
      @(posedge clk); #1;
    end
    if (resp_valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s resp_timeout: resp_valid=%b want 1", name, resp_valid);
      return;
    end
    n_checks++;
    if (cycle - acc !== lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, cycle - acc, lat); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_resp: got %b want 1", name, busy); end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL %s scoreboard_empty: got response %h want none", name, resp_data);
      return;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (resp_data !== exp) begin n_fail++; $display("FAIL %s data: got %h want %h", name, resp_data, exp); end
    if (resp_ready === 1'b1) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after_handshake: got valid=%b ready=%b busy=%b want 0 1 0", name, resp_valid, req_ready, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clear_model();
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: got ready=%b valid=%b data=%h busy=%b want 1 0 0 0", req_ready, resp_valid, resp_data, busy);
    end
    n_checks++;
    if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0 || b_resp_data !== '0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got ready=%b valid=%b data=%h busy=%b want 1 0 0 0", b_req_ready, b_resp_valid, b_resp_data, b_busy);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_default;
    int acc; logic [DW-1:0] e;
    resp_ready = 1'b1;
    issue(1'b0, 11'h123, '0, acc);
    if (acc >= 0) collect(acc, 4, "read_123", e);
  endtask

  task automatic test_write_read;
    int acc; logic [DW-1:0] e;
    issue(1'b1, 11'h2A3, 11'h055, acc);
    if (acc >= 0) collect(acc, 4, "write_2a3", e);
    issue(1'b0, 11'h2A3, '0, acc);
    if (acc >= 0) collect(acc, 4, "read_2a3", e);
    issue(1'b0, 11'h345, '0, acc);
    if (acc >= 0) collect(acc, 4, "read_345", e);
  endtask

  task automatic test_backpressure;
    int acc; logic [DW-1:0] e;
    resp_ready = 1'b0;
    issue(1'b0, 11'h2A3, '0, acc);
    if (acc >= 0) collect(acc, 4, "bp_read", e);
    req_write = 1'b1; req_addr = 11'h010; req_wdata = 11'h3FF; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== e || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1 %h 0", i, resp_valid, resp_data, req_ready, e);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ignored_req: got ready=%b want 1", req_ready); end
    issue(1'b0, 11'h010, '0, acc);
    if (acc >= 0) collect(acc, 4, "bp_read_010", e);
  endtask

  task automatic test_reset_mid;
    int acc; logic [DW-1:0] e;
    issue(1'b1, 11'h200, 11'h7FF, acc);
    if (acc >= 0) collect(acc, 4, "write_200", e);
    issue(1'b0, 11'h200, '0, acc);
    @(posedge clk); #1;
    rst = 1'b1; clear_model();
    #1;
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got busy=%b ready=%b valid=%b want 0 1 0", busy, req_ready, resp_valid);
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_quiet[%0d]: got valid=%b busy=%b want 0 0", i, resp_valid, busy);
      end
    end
    issue(1'b0, 11'h200, '0, acc);
    if (acc >= 0) collect(acc, 4, "read_200_after_rst", e);
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] e;
    b_resp_ready = 1'b1; b_req_write = 1'b0; b_req_addr = 11'h200; b_req_valid = 1'b1;
    n_checks++;
    if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", b_req_ready); end
    @(posedge clk); #1;
    exp_q.push_back(11'h200);
    b_req_addr = 11'h201;
    n_checks++;
    if (b_req_ready !== 1'b0 || b_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept1: got ready=%b valid=%b want 0 0", b_req_ready, b_resp_valid);
    end
    @(posedge clk); #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (b_resp_valid !== 1'b1 || b_resp_data !== e) begin
      n_fail++; $display("FAIL b2b_resp1: got valid=%b data=%h want 1 %h", b_resp_valid, b_resp_data, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hs1: got valid=%b ready=%b want 0 1", b_resp_valid, b_req_ready);
    end
    @(posedge clk); #1;
    exp_q.push_back(11'h201);
    b_req_valid = 1'b0;
    n_checks++;
    if (b_req_ready !== 1'b0 || b_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept2: got ready=%b valid=%b want 0 0", b_req_ready, b_resp_valid);
    end
    @(posedge clk); #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (b_resp_valid !== 1'b1 || b_resp_data !== e) begin
      n_fail++; $display("FAIL b2b_resp2: got valid=%b data=%h want 1 %h", b_resp_valid, b_resp_data, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hs2: got valid=%b ready=%b want 0 1", b_resp_valid, b_req_ready);
    end
  endtask

`ifdef MEM_RESPONDER_STATS_EN
  task automatic test_stats;
    int acc; logic [DW-1:0] e;
    rst = 1'b1; clear_model();
    @(posedge clk); #1; rst = 1'b0;
    resp_ready = 1'b1;
    issue(1'b0, 11'h001, '0, acc);     if (acc >= 0) collect(acc, 4, "st_r1", e);
    issue(1'b1, 11'h002, 11'h0AA, acc); if (acc >= 0) collect(acc, 4, "st_w1", e);
    issue(1'b0, 11'h002, '0, acc);     if (acc >= 0) collect(acc, 4, "st_r2", e);
    issue(1'b1, 11'h003, 11'h155, acc); if (acc >= 0) collect(acc, 4, "st_w2", e);
    issue(1'b0, 11'h004, '0, acc);     if (acc >= 0) collect(acc, 4, "st_r3", e);
    n_checks++;
    if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
      n_fail++; $display("FAIL stats_counts: got rd=%0d wr=%0d want 3 2", rd_count, wr_count);
    end
    rst = 1'b1; clear_model();
    #1;
    n_checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      n_fail++; $display("FAIL stats_reset: got rd=%0d wr=%0d want 0 0", rd_count, wr_count);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
    test_reset();
    test_read_default();
    test_write_read();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-store responder for the two-level cache hierarchy. It sits below the L2 and services its miss-fill and write-back requests over a valid/ready request channel and a valid/ready response channel. Every request gets a response after a fixed, parameterised latency. Default contents are deterministic, so cache benches can predict read data without preloading.

## Interface
- ADDR_WIDTH, 11, word-address width; storage depth is 2**ADDR_WIDTH words
- DATA_WIDTH, 11, data word width
- LATENCY, 4, cycles from request accept to resp_valid; legal range 1..255
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = write, 0 = read; sampled on accept
- req_addr  input  ADDR_WIDTH  word address; sampled on accept
- req_wdata  input  DATA_WIDTH  write data; sampled on accept
- resp_valid  output  1  response present
- resp_ready  input  1  requester consumes response
- resp_data  output  DATA_WIDTH  read data, or echoed write data for writes
- busy  output  1  high in any state other than IDLE

## Operation
- Storage: one array of 2**ADDR_WIDTH words plus a written-bit per word.
  - Written-bits clear asynchronously on rst; the data array is not reset.
  - A read of a word whose written-bit is 0 returns the default pattern: req_addr zero-extended or truncated to DATA_WIDTH (LSBs kept).
  - A read of a written word returns the stored data.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches addr, write and wdata, loads the counter with LATENCY-1, and moves to WAIT. Write requests commit to the array and set the written-bit at this accept edge.
  - WAIT: req_ready=0. The counter decrements each cycle. At counter==0 the FSM moves to RESP and loads resp_data.
    - Reads: array value, or the default pattern, at the latched address.
    - Writes: the latched wdata.
  - RESP: resp_valid=1. resp_data is held stable until resp_ready=1, then the FSM returns to IDLE.
- No overlap: one outstanding request at most. No request is accepted in the cycle the response handshake completes.
- Counter width is 8 bits. LATENCY=1 means WAIT lasts 1 cycle.

## Timing
- Reset values:
  - FSM state = IDLE.
  - req_ready=1, resp_valid=0, resp_data=0, busy=0.
  - All written-bits = 0.
- Accept at edge T: resp_valid rises after edge T+LATENCY; busy rises after edge T.
- Backpressure: while resp_ready=0 in RESP, resp_valid and resp_data hold indefinitely.
- Response handshake at edge R: resp_valid=0 and req_ready=1 after edge R. The earliest next accept is edge R+1.
- req_valid asserted while req_ready=0 is ignored. Inputs are not sampled and the requester must hold them.
- Read-after-write to the same address returns the new data. The write commits before any later accept.
- rst asserted mid-operation (WAIT or RESP) has the following effects:
  - Immediate return to IDLE; resp_valid drops and the pending response is discarded.
  - Written-bits clear, so memory reverts to the default pattern.
- Address wrap: none. Addresses are exact and every value 0..2**ADDR_WIDTH-1 is legal.

## Configuration
- Macro MEM_RESPONDER_STATS_EN.
- Defined: adds output ports rd_count[15:0] and wr_count[15:0].
  - Each counter increments on the accept edge of a read or write respectively.
  - Each saturates at 16'hFFFF.
  - Both reset asynchronously to 0.
- Undefined: neither port nor its counter logic exists. All other behaviour is identical.

## Test plan
- Reset, then read 11'h123 with LATENCY=4 -> resp_valid rises exactly 4 cycles after accept; resp_data=11'h123; busy high throughout.
- Write 11'h2A3 <- 11'h055, then read 11'h2A3 -> write response echoes 11'h055; read returns 11'h055; read of 11'h345 still returns 11'h345.
- Hold resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_data stable, req_ready=0; new req_valid is ignored. Release -> req_ready=1 the next cycle.
- Assert rst during WAIT after writing 11'h200 <- 11'h7FF -> resp_valid never rises, state IDLE; a subsequent read of 11'h200 returns 11'h200.
- LATENCY=1, back-to-back reads 11'h200 then 11'h201 with resp_ready tied high -> each response 1 cycle after accept; second accept is 1 cycle after the first response handshake; data 11'h200, 11'h201.
- With MEM_RESPONDER_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; after rst both counters = 0.
